// File: rtl/fft_bin_serializer.sv
// fft_bin_serializer: double-buffers 16-bin FFT frames and streams them one bin per valid/ready beat
module fft_bin_serializer #(
  parameter int DW = 32,
  parameter bit BITREV = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fft_valid,
  input  logic [DW-1:0] fft_d0,
  input  logic [DW-1:0] fft_d1,
  input  logic [DW-1:0] fft_d2,
  input  logic [DW-1:0] fft_d3,
  input  logic [DW-1:0] fft_d4,
  input  logic [DW-1:0] fft_d5,
  input  logic [DW-1:0] fft_d6,
  input  logic [DW-1:0] fft_d7,
  input  logic [DW-1:0] fft_d8,
  input  logic [DW-1:0] fft_d9,
  input  logic [DW-1:0] fft_d10,
  input  logic [DW-1:0] fft_d11,
  input  logic [DW-1:0] fft_d12,
  input  logic [DW-1:0] fft_d13,
  input  logic [DW-1:0] fft_d14,
  input  logic [DW-1:0] fft_d15,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_d,
  output logic [3:0]    out_idx,
  output logic          out_last,
  output logic          busy,
  output logic          drop
);
  logic [DW-1:0] din [16];
  logic [DW-1:0] bank_q [2][16];
  logic [DW-1:0] bank_d [2][16];
  logic [1:0] full_q, full_d;
  logic wb_q, wb_d, rb_q, rb_d, drop_q, drop_d;
  logic [3:0] cnt_q, cnt_d;
  logic cap, xfer;
  assign din = '{fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
                 fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15};
  assign out_valid = full_q[rb_q];
  assign out_idx = BITREV ? {cnt_q[0], cnt_q[1], cnt_q[2], cnt_q[3]} : cnt_q;
  assign out_d = bank_q[rb_q][out_idx];
  assign out_last = out_valid && cnt_q == 4'd15;
  assign busy = |full_q;
  assign drop = drop_q;
  // capture needs full[wb]=0 and retire needs full[rb]=1, so they never target the same bank
  always_comb begin
    cap = fft_valid && !full_q[wb_q];
    xfer = out_valid && out_ready;
    bank_d = bank_q;
    full_d = full_q;
    wb_d = wb_q;
    rb_d = rb_q;
    cnt_d = xfer ? cnt_q + 4'd1 : cnt_q;
    drop_d = fft_valid && full_q[wb_q];
    if (cap) begin
      bank_d[wb_q] = din;
      full_d[wb_q] = 1'b1;
      wb_d = ~wb_q;
    end
    if (xfer && cnt_q == 4'd15) begin
      full_d[rb_q] = 1'b0;
      rb_d = ~rb_q;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_q <= '{default: '0};
      full_q <= '0;
      wb_q <= 1'b0;
      rb_q <= 1'b0;
      cnt_q <= '0;
      drop_q <= 1'b0;
    end else begin
      bank_q <= bank_d;
      full_q <= full_d;
      wb_q <= wb_d;
      rb_q <= rb_d;
      cnt_q <= cnt_d;
      drop_q <= drop_d;
    end
  end
endmodule

// File: tb/tb_fft_bin_serializer.sv
// tb_fft_bin_serializer: natural and bit-reversed instances checked against a frame-FIFO model
module tb_fft_bin_serializer;
  logic clk = 0, rst = 0, fft_valid = 0, out_ready = 0;
  logic [31:0] din [16];
  logic v0, v1, l0, l1, b0, b1, dr0, dr1;
  logic [31:0] d0, d1;
  logic [3:0] i0, i1;
  int n_chk = 0, n_fail = 0, xfers = 0, drops = 0;
  int br_tab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  logic [31:0] mf [2][16];
  int mn = 0, pos = 0;
  logic mdrop = 0;

  always #5 clk = ~clk;

  fft_bin_serializer #(.DW(32), .BITREV(0)) dut0 (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(din[0]), .fft_d1(din[1]), .fft_d2(din[2]), .fft_d3(din[3]),
    .fft_d4(din[4]), .fft_d5(din[5]), .fft_d6(din[6]), .fft_d7(din[7]),
    .fft_d8(din[8]), .fft_d9(din[9]), .fft_d10(din[10]), .fft_d11(din[11]),
    .fft_d12(din[12]), .fft_d13(din[13]), .fft_d14(din[14]), .fft_d15(din[15]),
    .out_ready(out_ready), .out_valid(v0), .out_d(d0), .out_idx(i0),
    .out_last(l0), .busy(b0), .drop(dr0));

  fft_bin_serializer #(.DW(32), .BITREV(1)) dut1 (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(din[0]), .fft_d1(din[1]), .fft_d2(din[2]), .fft_d3(din[3]),
    .fft_d4(din[4]), .fft_d5(din[5]), .fft_d6(din[6]), .fft_d7(din[7]),
    .fft_d8(din[8]), .fft_d9(din[9]), .fft_d10(din[10]), .fft_d11(din[11]),
    .fft_d12(din[12]), .fft_d13(din[13]), .fft_d14(din[14]), .fft_d15(din[15]),
    .out_ready(out_ready), .out_valid(v1), .out_d(d1), .out_idx(i1),
    .out_last(l1), .busy(b1), .drop(dr1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: up to two whole frames in arrival order plus the beat position in the head frame
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mn = 0;
      pos = 0;
      mdrop = 0;
    end else begin
      automatic bit room = mn < 2;
      if (mn > 0 && out_ready) begin
        if (pos == 15) begin
          mf[0] = mf[1];
          mn--;
          pos = 0;
        end else pos++;
      end
      mdrop = fft_valid && !room;
      if (fft_valid && room) begin
        mf[mn] = din;
        mn++;
      end
    end
  end

  always @(posedge clk) if (rst) begin
    xfers += (v0 && out_ready) ? 1 : 0;
    drops += dr0 ? 1 : 0;
  end

  always @(negedge clk) begin
    chk("valid0", 32'(v0), 32'(mn > 0));
    chk("valid1", 32'(v1), 32'(mn > 0));
    chk("idx0", 32'(i0), pos);
    chk("idx1", 32'(i1), br_tab[pos]);
    chk("last0", 32'(l0), 32'(mn > 0 && pos == 15));
    chk("last1", 32'(l1), 32'(mn > 0 && pos == 15));
    chk("busy0", 32'(b0), 32'(mn > 0));
    chk("busy1", 32'(b1), 32'(mn > 0));
    chk("drop0", 32'(dr0), 32'(mdrop));
    chk("drop1", 32'(dr1), 32'(mdrop));
    if (mn > 0) begin
      chk("data0", d0, mf[0][pos]);
      chk("data1", d1, mf[0][br_tab[pos]]);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] base, input logic [31:0] mul);
    for (int k = 0; k < 16; k++) din[k] = base + mul * 32'(k);
    fft_valid = 1;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) din[k] = '0;
    #1;
    chk("rst_valid", 32'(v0), 0);
    chk("rst_busy", 32'(b0), 0);
    chk("rst_data", d0, 0);
    step(2);
    rst = 1;
    step(1);
    // single frame, ready held high
    load(0, 32'h0001_0001);
    out_ready = 1;
    step(1);
    fft_valid = 0;
    chk("s1_first_valid", 32'(v0), 1);
    chk("s1_first_idx", 32'(i0), 0);
    step(3);
    chk("s1_idx3", 32'(i0), 3);
    chk("s1_d3", d0, 32'h0003_0003);
    chk("s1_br_idx3", 32'(i1), 12);
    chk("s1_br_d3", d1, 32'h000C_000C);
    step(12);
    chk("s1_last", 32'(l0), 1);
    step(1);
    chk("s1_busy_after", 32'(b0), 0);
    chk("s1_no_drop", 32'(drops), 0);
    // backpressure 1,0,1,0
    load(32'h1000_0000, 32'h0000_0101);
    step(1);
    fft_valid = 0;
    xfers = 0;
    for (int c = 0; c < 32; c++) begin
      out_ready = (c % 2 == 0);
      step(1);
    end
    chk("bp_xfers", 32'(xfers), 16);
    chk("bp_busy_after", 32'(b0), 0);
    // overflow: three strobes 2 cycles apart, ready low
    out_ready = 0;
    drops = 0;
    load(32'hA000_0000, 1);
    step(1);
    fft_valid = 0;
    step(1);
    load(32'hB000_0000, 1);
    step(1);
    fft_valid = 0;
    step(1);
    load(32'hC000_0000, 1);
    step(1);
    fft_valid = 0;
    chk("ov_drop_pulse", 32'(dr0), 1);
    step(2);
    chk("ov_drops", 32'(drops), 1);
    chk("ov_head", d0, 32'hA000_0000);
    xfers = 0;
    out_ready = 1;
    step(16);
    chk("ov_second_frame", d0, 32'hB000_0000);
    step(16);
    chk("ov_xfers", 32'(xfers), 32);
    chk("ov_busy_after", 32'(b0), 0);
    // simultaneous retire and capture with both banks full
    out_ready = 0;
    load(32'hD000_0000, 1);
    step(1);
    fft_valid = 0;
    step(1);
    load(32'hE000_0000, 1);
    step(1);
    fft_valid = 0;
    out_ready = 1;
    step(15);
    chk("sim_at_last", 32'(l0), 1);
    load(32'hF000_0000, 1);
    step(1);
    fft_valid = 0;
    chk("sim_drop", 32'(dr0), 1);
    chk("sim_frame2", d0, 32'hE000_0000);
    step(15);
    chk("sim_last2", 32'(l0), 1);
    chk("sim_busy_hold", 32'(b0), 1);
    step(1);
    chk("sim_busy_fall", 32'(b0), 0);
    // asynchronous reset during beat 5
    load(32'h5000_0000, 32'h10);
    step(1);
    fft_valid = 0;
    step(5);
    chk("ar_beat5", d0, 32'h5000_0050);
    #1;
    rst = 0;
    #1;
    chk("ar_valid", 32'(v0), 0);
    chk("ar_busy", 32'(b0), 0);
    chk("ar_data0", d0, 0);
    chk("ar_data1", d1, 0);
    step(2);
    rst = 1;
    step(20);
    chk("ar_no_beats", 32'(v0), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fft_bin_serializer.md
# fft_bin_serializer

Output-side counterpart of the FIR/FFT/analyze chain. The FFT stage presents 16 spectral bins in parallel with a single-cycle `fft_valid` strobe. This block captures those frames into a two-bank buffer and streams them out one bin per beat over a valid/ready handshake. It sits after the FFT outputs and drives any downstream serial consumer (DMA, UART bridge, second analysis engine).

## Interface
- `DW`, default 32: bin width; bin format is {real[DW-1:DW/2], imag[DW/2-1:0]}, two's complement, passed through unmodified.
- `BITREV`, default 0: 0 = emit bins in natural order 0..15; 1 = emit in 4-bit bit-reversed order 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `fft_valid` input 1: one-cycle strobe; `fft_d0`..`fft_d15` are valid in the same cycle.
- `fft_d0`..`fft_d15` input DW each: the 16 bins, where `fft_dk` is bin k.
- `out_ready` input 1: consumer accepts the current beat.
- `out_valid` output 1: a beat is presented.
- `out_d` output DW: bin data for the current beat.
- `out_idx` output 4: true bin index of `out_d`.
- `out_last` output 1: high on the 16th beat of a frame.
- `busy` output 1: at least one bank holds an unsent or partially sent frame.
- `drop` output 1: one-cycle pulse when an incoming frame is discarded.

## Operation
- Storage: two banks, each 16 x DW registers. Per-bank `full` flag. Write-bank pointer `wb` and read-bank pointer `rb`, both 1 bit. Beat counter `cnt`, 4 bits.
- Capture: at a rising edge with `fft_valid`=1:
  - If `full[wb]`=0 (registered value before the edge): load all 16 bins into bank `wb`, set `full[wb]`, toggle `wb`.
  - Otherwise: discard the frame, leave bank contents and pointers unchanged, and assert `drop` for the next cycle.
- Emit:
  - `out_valid` = `full[rb]`.
  - `out_idx` = `cnt` (BITREV=0) or bitrev(`cnt`) (BITREV=1).
  - `out_d` = bank[`rb`][`out_idx`].
  - `out_last` = `out_valid` and `cnt`==15.
- Transfer occurs on an edge where `out_valid` and `out_ready` are both 1:
  - If `cnt`<15: `cnt`+1.
  - If `cnt`==15: `cnt`=0, clear `full[rb]`, toggle `rb`.
- `busy` = `full[0]` or `full[1]`.
- Handshake rules:
  - While `out_valid`=1 and `out_ready`=0, `out_d`, `out_idx` and `out_last` hold stable.
  - `out_valid` never drops before its frame completes.
  - `out_ready` may toggle freely.
- Simultaneous retire and capture: the free test uses pre-edge flags. If both banks are full on the edge where the last beat retires, an arriving frame is dropped, even though a bank frees on that edge.
- Capture into bank `wb` never disturbs bank `rb` while `rb` is being emitted; banks are distinct whenever both are in use.
- Frames are emitted strictly in capture order.

## Timing
- Reset (`rst` low) takes effect immediately, independent of `clk`. Resulting values:
  - `full`=00, `wb`=0, `rb`=0, `cnt`=0, all bank registers 0.
  - `out_valid`=0, `out_d`=0, `out_idx`=0, `out_last`=0, `busy`=0, `drop`=0.
- Reset mid-frame discards all buffered data; no beats appear after release until a new `fft_valid`.
- Latency: `fft_valid` sampled at edge N gives `out_valid`=1 and the first beat in the cycle after edge N.
- Throughput with `out_ready` held high: 16 beats in 16 consecutive cycles; `out_last` in cycle N+16.
- With `out_ready` high, one frame per 16 cycles is sustained without drops.
- `drop` is registered: high for exactly one cycle, the cycle after the rejected strobe.
- `busy` follows the `full` flags and falls in the cycle after the last transfer of the final buffered frame.

## Test plan
- Single frame, BITREV=0, `out_ready`=1. Stimulus: `fft_dk`=32'h0001_0000*k + k. Required response: `out_valid` starting the cycle after the strobe; `out_idx` 0..15 in consecutive cycles; `out_d` matching each bin; `out_last` only at idx 15; `busy` low afterward; `drop` never asserted.
- Backpressure: `out_ready` pattern 1,0,1,0,... on a single frame. Required response: 16 transfers over 32 cycles; `out_d` and `out_idx` held unchanged in every ready-low cycle.
- Overflow: three strobes 2 cycles apart with `out_ready`=0. Required response: frames 1 and 2 buffered; `drop` pulses once after strobe 3. When `out_ready` is then raised: 32 beats, all 16 of frame 1 followed by all 16 of frame 2.
- Simultaneous: both banks full, `fft_valid` coincides with the last beat of frame 1. Required response: `drop` pulses; frame 2 then streams; `busy` falls after its 16th beat.
- BITREV=1, same frame as the first scenario. Required response: `out_idx` sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15, with `out_d` equal to the bin at each index.
- Async reset: assert `rst` low mid-cycle during beat 5. Required response: `out_valid`, `busy`, `out_d` go to 0 without a clock edge; after release, no beats until the next `fft_valid`.
